// File: rtl/otg_hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus master.
//   hpi_state_t : bus-cycle sequencer states
//   HPI_REG_*   : HPI register select codes carried on avs_address / hpi_addr
package otg_hpi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } hpi_state_t;

    localparam logic [1:0] HPI_REG_DATA    = 2'd0;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

endpackage

// File: rtl/otg_hpi_sync2.sv
// Single-bit two-flop synchroniser, async active-low reset to 0.
//   clk, reset_n : destination clock and reset
//   d            : asynchronous input
//   q            : synchronised output
module otg_hpi_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/otg_hpi_bus_ctrl.sv
// Avalon-MM slave that turns each CPU access into one timed HPI bus cycle
// on the CY7C67200 EZ-OTG pins.
//   clk, reset_n        : system clock, async active-low reset
//   avs_*               : Avalon-MM slave (2-bit register select, 16-bit data)
//   hpi_addr/cs_n/rd_n/wr_n/data_out/data_oe : registered HPI pin drivers
//   hpi_data_in         : data from the pad
//   hpi_int / irq       : raw OTG interrupt and its synchronised level copy
module otg_hpi_bus_ctrl
    import otg_hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned RECOVER_CYC = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [1:0]  hpi_addr,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in,
    input  logic        hpi_int,
    output logic        irq
);

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LAST =
        CNT_W'((RECOVER_CYC == 32'd0) ? 32'd0 : RECOVER_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    hpi_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_dir_q, wr_dir_d;
    logic [1:0]        addr_q, addr_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic [15:0]       dout_q, dout_d;
    logic              oe_q, oe_d;
    logic [15:0]       rdata_q, rdata_d;

    // State and pin registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_dir_q <= 1'b0;
            addr_q   <= 2'd0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            dout_q   <= 16'd0;
            oe_q     <= 1'b0;
            rdata_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_dir_q <= wr_dir_d;
            addr_q   <= addr_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state and next-pin logic; counter saturates and clears on every transition
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        wr_dir_d = wr_dir_q;
        addr_d   = addr_q;
        cs_n_d   = cs_n_q;
        rd_n_d   = rd_n_q;
        wr_n_d   = wr_n_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (avs_read || avs_write) begin
                    // a simultaneous read+write is taken as a write
                    wr_dir_d = avs_write;
                    addr_d   = avs_address;
                    cs_n_d   = 1'b0;
                    if (avs_write) begin
                        dout_d = avs_writedata;
                        oe_d   = 1'b1;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    if (wr_dir_q) wr_n_d = 1'b0;
                    else          rd_n_d = 1'b0;
                    state_d = STROBE;
                    cnt_d   = '0;
                end
            end
            STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    // sample the pad on the edge that releases the strobe
                    if (!wr_dir_q) rdata_d = hpi_data_in;
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cs_n_d  = 1'b1;
                    oe_d    = 1'b0;
                    state_d = (RECOVER_CYC == 32'd0) ? IDLE : RECOVER;
                    cnt_d   = '0;
                end
            end
            RECOVER: begin
                if (cnt_q == RECOVER_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Access completes in the final HOLD cycle; stall everywhere else
    assign avs_waitrequest = !((state_q == HOLD) && (cnt_q == HOLD_LAST));

    assign avs_readdata = rdata_q;
    assign hpi_addr     = addr_q;
    assign hpi_cs_n     = cs_n_q;
    assign hpi_rd_n     = rd_n_q;
    assign hpi_wr_n     = wr_n_q;
    assign hpi_data_out = dout_q;
    assign hpi_data_oe  = oe_q;

    otg_hpi_sync2 u_irq_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (hpi_int),
        .q       (irq)
    );

endmodule
